// File: rtl/ootx_pkg.sv
// Shared definitions for the lighthouse OOTX frame decoder: state encoding,
// CRC-32 constants and a byte-wide reflected CRC-32 update function.
package ootx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } state_t;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  localparam int unsigned DEFAULT_PREAMBLE_ZEROS = 17;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ootx_crc32.sv
// Registered CRC-32 accumulator fed one payload byte per byte_en pulse.
module ootx_crc32
  import ootx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC32_INIT;
    end else if (clear) begin
      crc <= CRC32_INIT;
    end else if (byte_en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/lighthouse_ootx_decoder.sv
// Reassembles lighthouse OOTX frames from per-sync-pulse data bits and streams payload bytes.
// Define OOTX_CRC_EN to build the CRC-32 check; otherwise crc_ok reads 1 on every frame_done.
module lighthouse_ootx_decoder
  import ootx_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned PREAMBLE_ZEROS = DEFAULT_PREAMBLE_ZEROS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_strobe,
  output logic [7:0]  byte_out,
  output logic        byte_strobe,
  output logic        frame_start,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        error,
  output logic [15:0] length
);

  localparam int unsigned   ZW   = $clog2(PREAMBLE_ZEROS + 1);
  localparam logic [ZW-1:0] ZMAX = ZW'(PREAMBLE_ZEROS);

  state_t        r_state;
  logic [ZW-1:0] r_zcount;
  logic [3:0]    r_bitcnt;
  logic          r_sync;
  logic          r_crc_hi;
  logic [15:0]   r_shift;
  logic [15:0]   r_bytes_left;
  logic [7:0]    r_hold;
  logic          r_emit2;

  logic [15:0]   w_shift_next;
  logic [15:0]   w_len;
  logic          w_crc_ok;

  assign w_shift_next = {r_shift[14:0], bit_in};
  assign w_len        = {r_shift[7:0], r_shift[15:8]};

`ifdef OOTX_CRC_EN
  logic [15:0] r_crc_lo;
  logic [31:0] w_crc_acc;
  logic [31:0] w_crc_rx;

  ootx_crc32 u_crc (
    .clk     (clk),
    .reset   (reset),
    .clear   (frame_start),
    .byte_en (byte_strobe),
    .data    (byte_out),
    .crc     (w_crc_acc)
  );

  // Received CRC bytes arrive c0,c1 then c2,c3.
  assign w_crc_rx = {w_shift_next[7:0], w_shift_next[15:8], r_crc_lo[7:0], r_crc_lo[15:8]};
  assign w_crc_ok = ((w_crc_acc ^ CRC32_XOROUT) == w_crc_rx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc_lo <= 16'd0;
    end else if (bit_strobe && r_state == ST_CRC && !r_sync && r_bitcnt == 4'd15 && !r_crc_hi) begin
      r_crc_lo <= w_shift_next;
    end
  end
`else
  assign w_crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_HUNT;
      r_zcount     <= '0;
      r_bitcnt     <= 4'd0;
      r_sync       <= 1'b0;
      r_crc_hi     <= 1'b0;
      r_shift      <= 16'd0;
      r_bytes_left <= 16'd0;
      r_hold       <= 8'd0;
      r_emit2      <= 1'b0;
      byte_out     <= 8'd0;
      byte_strobe  <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      crc_ok       <= 1'b0;
      error        <= 1'b0;
      length       <= 16'd0;
    end else begin
      byte_strobe <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      if (r_emit2) begin
        byte_out    <= r_hold;
        byte_strobe <= 1'b1;
        r_emit2     <= 1'b0;
      end

      if (bit_strobe) begin
        case (r_state)
          ST_HUNT: begin
            if (!bit_in) begin
              if (r_zcount != ZMAX) r_zcount <= r_zcount + ZW'(1);
            end else begin
              if (r_zcount == ZMAX) begin
                r_state  <= ST_LEN;
                r_bitcnt <= 4'd0;
                r_sync   <= 1'b0;
                r_crc_hi <= 1'b0;
              end
              r_zcount <= '0;
            end
          end

          default: begin
            if (r_sync) begin
              r_sync <= 1'b0;
              if (!bit_in) begin
                // A failed sync zero is also the first zero of the next preamble.
                error    <= 1'b1;
                r_state  <= ST_HUNT;
                r_zcount <= ZW'(1);
              end else begin
                case (r_state)
                  ST_LEN: begin
                    if (w_len > 16'(MAX_LEN)) begin
                      error    <= 1'b1;
                      r_state  <= ST_HUNT;
                      r_zcount <= '0;
                    end else begin
                      frame_start  <= 1'b1;
                      length       <= w_len;
                      r_bytes_left <= w_len;
                      crc_ok       <= 1'b0;
                      r_state      <= (w_len == 16'd0) ? ST_CRC : ST_PAYLOAD;
                    end
                  end
                  ST_PAYLOAD: begin
                    if (r_bytes_left == 16'd0) r_state <= ST_CRC;
                  end
                  default: ;
                endcase
              end
            end else begin
              r_shift  <= w_shift_next;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd15) begin
                case (r_state)
                  ST_PAYLOAD: begin
                    byte_out     <= w_shift_next[15:8];
                    byte_strobe  <= 1'b1;
                    r_hold       <= w_shift_next[7:0];
                    r_emit2      <= (r_bytes_left > 16'd1);
                    r_bytes_left <= (r_bytes_left > 16'd1) ? r_bytes_left - 16'd2 : 16'd0;
                    r_sync       <= 1'b1;
                  end
                  ST_CRC: begin
                    if (!r_crc_hi) begin
                      r_crc_hi <= 1'b1;
                      r_sync   <= 1'b1;
                    end else begin
                      frame_done <= 1'b1;
                      crc_ok     <= w_crc_ok;
                      r_state    <= ST_HUNT;
                      r_zcount   <= '0;
                    end
                  end
                  default: r_sync <= 1'b1;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule
